// File: rtl/idivmod_pkg.sv
// Shared types and helpers for the iterative divide/modulo unit.
// Arithmetic helpers work on 64-bit values; callers cast to WIDTH.
package idivmod_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_LOOP,
    S_FIX
  } state_t;

  function automatic logic [63:0] neg_w(
    input logic [63:0] x
  );
    return ~x + 64'd1;
  endfunction

  function automatic logic [63:0] abs_w(
    input logic [63:0] x,
    input logic [5:0]  msb
  );
    return x[msb] ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/idiv_step.sv
// One radix-2 restoring step: shift in a bit, trial-subtract.
// The compare is done on WIDTH+1 bits so the shifted carry is kept.
module idiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             nbit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] rp;

  // trial subtraction; result always fits WIDTH bits since r < d
  always_comb begin
    rp    = {r, nbit};
    q_bit = (rp >= {1'b0, d});
    r_nxt = q_bit ? WIDTH'(rp - {1'b0, d})
                  : rp[WIDTH-1:0];
  end

endmodule

// File: rtl/idivmod_seq.sv
// Fixed-latency signed/unsigned divider with rq/ack handshake.
// Zero and overflow cases run the full loop and override at FIX.
module idivmod_seq
  import idivmod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rq,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ack,
  output logic [WIDTH-1:0] div_out,
  output logic [WIDTH-1:0] div_mod,
  output logic             dz,
  output logic             ovf
);

  localparam logic [5:0] MSB = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, b_abs;
  logic [WIDTH-1:0] sreg, q, r;
  logic [CNT_W-1:0] cnt;
  logic             sm_q, neg_q, neg_r;
  logic             zero, ovf_c;

  logic [WIDTH-1:0] a_abs_c, b_abs_c;
  logic [WIDTH-1:0] r_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             fix_dz, fix_ovf;

  idiv_step #(.WIDTH(WIDTH)) u_step (
    .r     (r),
    .nbit  (sreg[WIDTH-1]),
    .d     (b_abs),
    .r_nxt (r_nxt),
    .q_bit (q_bit)
  );

  // operand magnitudes for the PREP cycle
  always_comb begin
    a_abs_c = sm_q ? WIDTH'(abs_w(64'(a_q), MSB)) : a_q;
    b_abs_c = sm_q ? WIDTH'(abs_w(64'(b_q), MSB)) : b_q;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (rq) state_nxt = S_PREP;
      S_PREP: state_nxt = S_LOOP;
      S_LOOP: if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // final result selection, sign fix-up and special cases
  always_comb begin
    fix_q   = '0;
    fix_r   = '0;
    fix_dz  = 1'b0;
    fix_ovf = 1'b0;
    unique case (1'b1)
      zero: begin
        fix_q  = '1;
        fix_r  = a_q;
        fix_dz = 1'b1;
      end
      ovf_c: begin
        fix_q   = MIN_V;
        fix_ovf = 1'b1;
      end
      default: begin
        fix_q = neg_q ? WIDTH'(neg_w(64'(q))) : q;
        fix_r = neg_r ? WIDTH'(neg_w(64'(r))) : r;
      end
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      b_abs   <= '0;
      sreg    <= '0;
      q       <= '0;
      r       <= '0;
      cnt     <= '0;
      sm_q    <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      zero    <= 1'b0;
      ovf_c   <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      div_out <= '0;
      div_mod <= '0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ack <= 1'b0;
      unique case (state)
        S_IDLE: if (rq) begin
          a_q  <= dividend;
          b_q  <= divisor;
          sm_q <= signed_mode;
          busy <= 1'b1;
        end
        S_PREP: begin
          b_abs <= b_abs_c;
          sreg  <= a_abs_c;
          q     <= '0;
          r     <= '0;
          cnt   <= CNT_W'(WIDTH);
          neg_q <= sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= sm_q & a_q[WIDTH-1];
          zero  <= (b_q == '0);
          ovf_c <= sm_q && (a_q == MIN_V) && (b_q == '1);
        end
        S_LOOP: begin
          r    <= r_nxt;
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          q    <= {q[WIDTH-2:0], q_bit};
          cnt  <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          div_out <= fix_q;
          div_mod <= fix_r;
          dz      <= fix_dz;
          ovf     <= fix_ovf;
          ack     <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idivmod_seq.sv
// Directed bench for idivmod_seq (32-bit) plus an 8-bit sweep.
// Expected values are hand-computed or from native SV division.
module tb_idivmod_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rq = 1'b0, sm = 1'b0;
  logic [31:0] dvd = '0, dvs = '0;
  logic        busy, ack, dz, ovf;
  logic [31:0] q, r;

  logic        rq8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  dvd8 = '0, dvs8 = '0;
  logic        busy8, ack8, dz8, ovf8;
  logic [7:0]  q8, r8;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  idivmod_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .rq(rq),
    .signed_mode(sm), .dividend(dvd), .divisor(dvs),
    .busy(busy), .ack(ack), .div_out(q), .div_mod(r),
    .dz(dz), .ovf(ovf)
  );

  idivmod_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .rq(rq8),
    .signed_mode(sm8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .ack(ack8), .div_out(q8), .div_mod(r8),
    .dz(dz8), .ovf(ovf8)
  );

  task automatic start_op(input logic s,
                          input logic [31:0] a, b);
    @(negedge clk);
    rq = 1'b1; sm = s; dvd = a; dvs = b;
    @(posedge clk); #1;
    rq = 1'b0; dvd = $urandom; dvs = $urandom;
  endtask

  task automatic wait_ack(output int lat, output bit bok);
    lat = 0; bok = 1'b1;
    while (!ack && lat < 100) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) bok = 1'b0;
  endtask

  task automatic do_op(input logic s,
                       input logic [31:0] a, b,
                       output int lat, output bit bok);
    start_op(s, a, b);
    wait_ack(lat, bok);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] eq, er,
                     input logic edz, eovf, input int lat);
    vec++;
    if (q !== eq || r !== er || dz !== edz ||
        ovf !== eovf || lat != 34) begin
      errs++;
      $display("FAIL %s: got q=%h r=%h dz=%b ovf=%b lat=%0d want q=%h r=%h dz=%b ovf=%b lat=34",
               nm, q, r, dz, ovf, lat, eq, er, edz, eovf);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({busy, ack, q, r, dz, ovf} !== '0 ||
        {busy8, ack8, q8, r8, dz8, ovf8} !== '0) begin
      errs++;
      $display("FAIL reset: got busy=%b ack=%b q=%h r=%h dz=%b ovf=%b want all 0",
               busy, ack, q, r, dz, ovf);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat; bit bok;
    do_op(1'b0, 32'd100, 32'd7, lat, bok);
    chk("u100/7", 32'd14, 32'd2, 1'b0, 1'b0, lat);
    vec++;
    if (!bok) begin
      errs++;
      $display("FAIL busy_window: got glitch want high until ack");
    end
    @(posedge clk); #1;
    vec++;
    if (ack !== 1'b0 || q !== 32'd14 || r !== 32'd2) begin
      errs++;
      $display("FAIL hold: got ack=%b q=%h r=%h want 0 0000000e 00000002",
               ack, q, r);
    end
  endtask

  task automatic test_signed;
    int lat; bit bok;
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, bok);
    chk("s-7/2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, lat);
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, lat, bok);
    chk("s7/-2", 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, lat);
    do_op(1'b0, 32'hFFFFFFF9, 32'd2, lat, bok);
    chk("u_f9/2", 32'h7FFFFFFC, 32'd1, 1'b0, 1'b0, lat);
  endtask

  task automatic test_div_zero;
    int lat; bit bok;
    do_op(1'b0, 32'd5, 32'd0, lat, bok);
    chk("u5/0", 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, lat);
    do_op(1'b1, 32'd5, 32'd0, lat, bok);
    chk("s5/0", 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, lat);
  endtask

  task automatic test_overflow;
    int lat; bit bok;
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bok);
    chk("s_ovf", 32'h80000000, 32'd0, 1'b0, 1'b1, lat);
    do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, bok);
    chk("u_min/ones", 32'd0, 32'h80000000, 1'b0, 1'b0, lat);
  endtask

  task automatic test_ignore_rq;
    int lat; bit bok; int extra;
    start_op(1'b0, 32'd1000, 32'd10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rq = 1'b1; dvd = 32'd9; dvs = 32'd3;
    @(negedge clk); rq = 1'b0;
    @(posedge clk); #1;
    wait_ack(lat, bok);
    chk("busy_rq", 32'd100, 32'd0, 1'b0, 1'b0, lat + 7);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ack) extra++;
    end
    vec++;
    if (extra != 0) begin
      errs++;
      $display("FAIL no_queue: got %0d extra acks want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit bok;
    do_op(1'b0, 32'd50, 32'd6, lat, bok);
    rq = 1'b1; sm = 1'b1; dvd = 32'hFFFFFF9C; dvs = 32'd7;
    chk("b2b_first", 32'd8, 32'd2, 1'b0, 1'b0, lat);
    @(posedge clk); #1;
    rq = 1'b0;
    wait_ack(lat, bok);
    chk("b2b_second", 32'hFFFFFFF2, 32'hFFFFFFFE,
        1'b0, 1'b0, lat);
  endtask

  task automatic test_reset_mid;
    int lat; bit bok; int acks;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    vec++;
    if ({busy, ack, q, r, dz, ovf} !== '0) begin
      errs++;
      $display("FAIL mid_reset: got busy=%b ack=%b q=%h r=%h want all 0",
               busy, ack, q, r);
    end
    @(negedge clk); reset = 1'b0;
    acks = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    vec++;
    if (acks != 0) begin
      errs++;
      $display("FAIL abort_ack: got %0d acks want 0", acks);
    end
    do_op(1'b0, 32'd100, 32'd7, lat, bok);
    chk("after_reset", 32'd14, 32'd2, 1'b0, 1'b0, lat);
  endtask

  task automatic test_w8_sweep;
    logic [7:0] vals [32];
    logic [7:0] eq, er;
    logic edz, eovf;
    int lat, sa, sb;
    for (int i = 0; i < 29; i++) vals[i] = 8'(i * 9);
    vals[29] = 8'h7F; vals[30] = 8'h80; vals[31] = 8'hFF;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++) begin
          sa = int'($signed(vals[i]));
          sb = int'($signed(vals[j]));
          edz = 1'b0; eovf = 1'b0;
          if (vals[j] == 8'd0) begin
            eq = 8'hFF; er = vals[i]; edz = 1'b1;
          end else if (m == 1 && vals[i] == 8'h80 &&
                       vals[j] == 8'hFF) begin
            eq = 8'h80; er = 8'h00; eovf = 1'b1;
          end else if (m == 1) begin
            eq = 8'(sa / sb); er = 8'(sa % sb);
          end else begin
            eq = vals[i] / vals[j]; er = vals[i] % vals[j];
          end
          @(negedge clk);
          rq8 = 1'b1; sm8 = 1'(m);
          dvd8 = vals[i]; dvs8 = vals[j];
          @(posedge clk); #1;
          rq8 = 1'b0;
          lat = 0;
          while (!ack8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
          end
          vec++;
          if (q8 !== eq || r8 !== er || dz8 !== edz ||
              ovf8 !== eovf || lat != 10) begin
            errs++;
            $display("FAIL w8 m=%0d %h/%h: got q=%h r=%h dz=%b ovf=%b lat=%0d want q=%h r=%h dz=%b ovf=%b lat=10",
                     m, vals[i], vals[j], q8, r8, dz8, ovf8,
                     lat, eq, er, edz, eovf);
          end
        end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_rq();
    test_back_to_back();
    test_reset_mid();
    test_w8_sweep();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
